running_man_control: RTL and testbench
======================================

# running_man_control

Sequencing controller that sits directly upstream of the running-man drawing datapath. After reset it commands one floor draw. It then loops once per frame: load sprite position/style, draw the man, wait out the frame, erase, and compute the next position. It turns player keys (jump, crouch) into a running/jumping/crouching man that advances right and drops to the next floor lane on wrap.

## Interface
- FRAME_CYCLES, 833333, clk cycles spent in WAIT per frame (60 Hz at 50 MHz); minimum 2
- JUMP_H, 8, jump apex height in pixels; the ascent and the descent each last JUMP_H frames
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- jump_key  in  1  active-high level/pulse, jump request
- crouch_key  in  1  active-high level, crouch while held
- draw_floors_finish  in  1  level from datapath, floors complete
- draw_man_finish  in  1  level from datapath, sprite draw complete
- erase_finish  in  1  level from datapath, sprite erase complete
- drawing_floors  out  1  high in FLOORS
- draw_man  out  1  high in DRAW
- erase  out  1  high in ERASE
- plot  out  1  drawing_floors | draw_man | erase
- ld_x, ld_y, ld_man_style  out  1 each  high for exactly the LOAD cycle
- x_out  out  8  sprite left column, valid while ld_x
- y_out  out  7  sprite top row, valid while ld_y
- man_style  out  1  1 = normal, 0 = crouch; valid while ld_man_style

## Operation
- States: RST, FLOORS, LOAD, DRAW, WAIT, ERASE, UPDATE. Outputs are a Moore decode of the state.
- RST → FLOORS unconditionally.
- FLOORS → LOAD when draw_floors_finish = 1.
- LOAD → DRAW after 1 cycle.
- DRAW → WAIT when draw_man_finish = 1.
- WAIT → ERASE when frame_cnt = FRAME_CYCLES-1. frame_cnt clears on WAIT entry.
- ERASE → LOAD... no: ERASE → UPDATE when erase_finish = 1.
- UPDATE → LOAD after 1 cycle.
- Lanes: lane ∈ {0,1,2}, with floor tops 35/75/115. Grounded y = 28/68/108 (sprite height 7).
- Registers: x_pos (8b), lane (2b), jump_cnt (0..2·JUMP_H, 0 = grounded), style.
- jump_req and crouch_req are sticky. They are set by their key in any state from LOAD through ERASE and cleared in UPDATE.
- UPDATE, evaluated in this priority order:
  - If grounded and jump_req: jump_cnt = 1, style = 1 (jump wins over crouch).
  - Else if grounded: style = ~crouch_req.
  - Else (airborne): jump_cnt++; when it reaches 2·JUMP_H+1 it returns to 0 (landed). style = 1; crouch is ignored.
  - x_pos: if x_pos = 152 and grounded after this update → x_pos = 0 and lane = (lane+1) mod 3 (lane 2 wraps to 0). If x_pos = 152 and airborne → hold at 152. Otherwise x_pos + 1.
- y_out = ground_y(lane) − h, where h = jump_cnt for jump_cnt ≤ JUMP_H, else 2·JUMP_H − jump_cnt.
- x_out, y_out and man_style are driven from the registers at all times. They are only meaningful while the ld_* strobes are high.
- Arithmetic is unsigned. y never underflows because JUMP_H ≤ 28 is required.

## Timing
- Reset values: state RST; all outputs 0; x_pos = 25; lane = 0; y_out = 28; jump_cnt = 0; style = 1; requests = 0; frame_cnt = 0.
- drawing_floors rises on the 2nd edge after reset deasserts (RST lasts 1 cycle).
- Finish inputs are sampled levels. A finish already high on DRAW/ERASE entry causes exit on the next edge (minimum dwell 1 cycle).
- draw_man and erase are never high together. No strobe is active in RST.
- Each frame, DRAW is entered exactly 1 cycle after the ld_* strobe. UPDATE → LOAD takes 1 cycle.
- WAIT dwell is exactly FRAME_CYCLES cycles.
- Reset asserted in any state: on the next edge the controller returns to RST values, and all outputs drop in that same cycle.
- A key pulse of 1 cycle anywhere from LOAD to ERASE is captured. Keys during FLOORS, UPDATE or RST are ignored.

## Test plan
- Reset then floors: hold draw_floors_finish = 0 for 10 cycles → drawing_floors stays 1, plot = 1. Raise it → 1 cycle later ld_x = ld_y = ld_man_style = 1 with x_out = 25, y_out = 28, man_style = 1.
- Plain running, FRAME_CYCLES = 4, finishes tied high: successive LOAD x_out = 25, 26, 27 at y_out = 28. WAIT measured at exactly 4 cycles.
- Jump, JUMP_H = 3: 1-cycle jump_key pulse during WAIT → next LOAD y_out = 27, then 26, 25, 26, 27, 28. A second jump pulse while airborne is ignored.
- Crouch: hold crouch_key → next LOAD man_style = 0. Press crouch and jump in the same frame while grounded → man_style = 1 and y_out = 27.
- Wrap: preload x_pos to 152 on lane 2 while grounded → next LOAD x_out = 0, y_out = 28 (lane 0). Same setup but airborne → x_out holds at 152 until landing.
- Reset mid-DRAW: assert reset → next cycle all outputs 0. After release, FLOORS is re-entered and x_out = 25.

Source files
------------

// File: rtl/running_man_control.sv
`default_nettype none
// ============================================================================
// Module   : running_man_control
// Purpose  : Frame sequencer for the running-man sprite: floors, load, draw,
//            wait, erase, update, with jump/crouch/lane-wrap motion rules.
// Revision : 1.0 - initial release
// ============================================================================
module running_man_control #(
    parameter int FRAME_CYCLES = 833333,
    parameter int JUMP_H       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump_key,
    input  logic       crouch_key,
    input  logic       draw_floors_finish,
    input  logic       draw_man_finish,
    input  logic       erase_finish,
    output logic       drawing_floors,
    output logic       draw_man,
    output logic       erase,
    output logic       plot,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_man_style,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       man_style
);

    localparam int FCW = $clog2(FRAME_CYCLES);
    localparam int JCW = $clog2(2 * JUMP_H + 2);

    localparam logic [FCW-1:0] c_FRAME_LAST = FCW'(FRAME_CYCLES - 1);
    localparam logic [FCW-1:0] c_FRAME_ONE  = FCW'(1);
    localparam logic [JCW-1:0] c_JC_ONE     = JCW'(1);
    localparam logic [JCW-1:0] c_JC_APEX    = JCW'(JUMP_H);
    localparam logic [JCW-1:0] c_JC_LAST    = JCW'(2 * JUMP_H);
    localparam logic [7:0]     c_X_START    = 8'd25;
    localparam logic [7:0]     c_X_LAST     = 8'd152;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FLOORS = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DRAW   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_ERASE  = 3'd5,
        ST_UPDATE = 3'd6
    } state_t;

    state_t         state_q,      state_d;
    logic [FCW-1:0] frame_cnt_q,  frame_cnt_d;
    logic [7:0]     x_pos_q,      x_pos_d;
    logic [1:0]     lane_q,       lane_d;
    logic [JCW-1:0] jump_cnt_q,   jump_cnt_d;
    logic           style_q,      style_d;
    logic           jump_req_q,   jump_req_d;
    logic           crouch_req_q, crouch_req_d;

    logic [6:0]     w_ground_y;
    logic [JCW-1:0] w_height;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RST;
            frame_cnt_q  <= '0;
            x_pos_q      <= c_X_START;
            lane_q       <= 2'd0;
            jump_cnt_q   <= '0;
            style_q      <= 1'b1;
            jump_req_q   <= 1'b0;
            crouch_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            x_pos_q      <= x_pos_d;
            lane_q       <= lane_d;
            jump_cnt_q   <= jump_cnt_d;
            style_q      <= style_d;
            jump_req_q   <= jump_req_d;
            crouch_req_q <= crouch_req_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        x_pos_d      = x_pos_q;
        lane_d       = lane_q;
        jump_cnt_d   = jump_cnt_q;
        style_d      = style_q;
        jump_req_d   = jump_req_q;
        crouch_req_d = crouch_req_q;

        // Keys are only captured while a frame is in flight (LOAD..ERASE).
        if (state_q == ST_LOAD || state_q == ST_DRAW ||
            state_q == ST_WAIT || state_q == ST_ERASE) begin
            jump_req_d   = jump_req_q   | jump_key;
            crouch_req_d = crouch_req_q | crouch_key;
        end

        case (state_q)
            ST_RST:    state_d = ST_FLOORS;
            ST_FLOORS: if (draw_floors_finish) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_DRAW;
            ST_DRAW: begin
                if (draw_man_finish) begin
                    state_d     = ST_WAIT;
                    frame_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (frame_cnt_q == c_FRAME_LAST) state_d = ST_ERASE;
                else                             frame_cnt_d = frame_cnt_q + c_FRAME_ONE;
            end
            ST_ERASE:  if (erase_finish) state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d      = ST_LOAD;
                jump_req_d   = 1'b0;
                crouch_req_d = 1'b0;
                if (jump_cnt_q == '0) begin
                    if (jump_req_q) begin
                        jump_cnt_d = c_JC_ONE;
                        style_d    = 1'b1;
                    end else begin
                        style_d    = ~crouch_req_q;
                    end
                end else begin
                    jump_cnt_d = (jump_cnt_q == c_JC_LAST) ? '0 : jump_cnt_q + c_JC_ONE;
                    style_d    = 1'b1;
                end
                // At the right edge the man only drops a lane once he is on the ground.
                if (x_pos_q == c_X_LAST) begin
                    if (jump_cnt_d == '0) begin
                        x_pos_d = 8'd0;
                        lane_d  = (lane_q == 2'd2) ? 2'd0 : lane_q + 2'd1;
                    end
                end else begin
                    x_pos_d = x_pos_q + 8'd1;
                end
            end
            default:   state_d = ST_RST;
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    w_ground_y = 7'd28;
            2'd1:    w_ground_y = 7'd68;
            default: w_ground_y = 7'd108;
        endcase
        w_height = (jump_cnt_q <= c_JC_APEX) ? jump_cnt_q : c_JC_LAST - jump_cnt_q;
    end

    assign drawing_floors = (state_q == ST_FLOORS);
    assign draw_man       = (state_q == ST_DRAW);
    assign erase          = (state_q == ST_ERASE);
    assign plot           = drawing_floors | draw_man | erase;
    assign ld_x           = (state_q == ST_LOAD);
    assign ld_y           = (state_q == ST_LOAD);
    assign ld_man_style   = (state_q == ST_LOAD);
    assign x_out          = x_pos_q;
    assign y_out          = w_ground_y - 7'(w_height);
    assign man_style      = style_q;

endmodule
`default_nettype wire

// File: tb/tb_running_man_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_running_man_control
// Purpose  : Randomized frame-level bench with a motion reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_running_man_control;

    localparam int FC     = 4;
    localparam int JH     = 3;
    localparam int FRAMES = 800;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jump_key = 1'b0;
    logic       crouch_key = 1'b0;
    logic       draw_floors_finish = 1'b0;
    logic       draw_man_finish = 1'b0;
    logic       erase_finish = 1'b0;
    logic       drawing_floors, draw_man, erase, plot;
    logic       ld_x, ld_y, ld_man_style, man_style;
    logic [7:0] x_out;
    logic [6:0] y_out;

    int errors = 0;
    int checks = 0;

    int m_x, m_lane, m_jc, m_style, m_jreq, m_creq;
    int wraps = 0;
    int holds = 0;

    running_man_control #(.FRAME_CYCLES(FC), .JUMP_H(JH)) dut (
        .clk(clk), .reset(reset), .jump_key(jump_key), .crouch_key(crouch_key),
        .draw_floors_finish(draw_floors_finish), .draw_man_finish(draw_man_finish),
        .erase_finish(erase_finish), .drawing_floors(drawing_floors),
        .draw_man(draw_man), .erase(erase), .plot(plot), .ld_x(ld_x), .ld_y(ld_y),
        .ld_man_style(ld_man_style), .x_out(x_out), .y_out(y_out),
        .man_style(man_style)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_y();
        int h;
        h = (m_jc <= JH) ? m_jc : 2 * JH - m_jc;
        return 28 + 40 * m_lane - h;
    endfunction

    task automatic model_reset();
        m_x = 25; m_lane = 0; m_jc = 0; m_style = 1; m_jreq = 0; m_creq = 0;
    endtask

    // Motion rules applied once per frame, at the UPDATE step.
    task automatic model_update();
        if (m_jc == 0 && m_jreq != 0) begin
            m_jc = 1; m_style = 1;
        end else if (m_jc == 0) begin
            m_style = (m_creq != 0) ? 0 : 1;
        end else begin
            m_jc = (m_jc + 1) % (2 * JH + 1);
            m_style = 1;
        end
        if (m_x == 152) begin
            if (m_jc == 0) begin
                m_x = 0; m_lane = (m_lane + 1) % 3; wraps++;
            end else begin
                holds++;
            end
        end else begin
            m_x = m_x + 1;
        end
        m_jreq = 0; m_creq = 0;
    endtask

    task automatic drive_live_keys(input int crouch_hold);
        int jodds;
        jodds = (m_x >= 149) ? 3 : 24;
        jump_key   = ($urandom_range(0, jodds) == 0);
        crouch_key = (crouch_hold != 0) || ($urandom_range(0, 19) == 0);
        if (jump_key)   m_jreq = 1;
        if (crouch_key) m_creq = 1;
    endtask

    task automatic drive_ignored_keys();
        jump_key   = ($urandom_range(0, 2) == 0);
        crouch_key = ($urandom_range(0, 2) == 0);
    endtask

    task automatic check_load();
        check("ld_x", ld_x, 1);
        check("ld_y", ld_y, 1);
        check("ld_man_style", ld_man_style, 1);
        check("load_plot", plot, 0);
        check("x_out", x_out, m_x);
        check("y_out", y_out, exp_y());
        check("man_style", man_style, m_style);
    endtask

    task automatic run_frame();
        int ch, kd, ke;
        ch = ($urandom_range(0, 3) == 0) ? 1 : 0;
        kd = $urandom_range(0, 3);
        ke = $urandom_range(0, 3);
        check_load();
        draw_man_finish = (kd == 0);
        drive_live_keys(ch);
        tick();
        for (int i = 0; i <= kd; i++) begin
            check("draw_man", draw_man, 1);
            check("erase_in_draw", erase, 0);
            check("ld_in_draw", ld_x, 0);
            draw_man_finish = (i == kd);
            drive_live_keys(ch);
            tick();
        end
        draw_man_finish = 1'b0;
        for (int i = 0; i < FC; i++) begin
            check("wait_plot", plot, 0);
            check("wait_ld", ld_x, 0);
            erase_finish = (i == FC - 1) && (ke == 0);
            drive_live_keys(ch);
            tick();
        end
        for (int i = 0; i <= ke; i++) begin
            check("erase", erase, 1);
            check("draw_in_erase", draw_man, 0);
            erase_finish = (i == ke);
            drive_live_keys(ch);
            tick();
        end
        erase_finish = 1'b0;
        check("update_plot", plot, 0);
        check("update_ld", ld_x, 0);
        drive_ignored_keys();
        tick();
        model_update();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_floors"}, drawing_floors, 0);
        check({tag, "_draw"}, draw_man, 0);
        check({tag, "_erase"}, erase, 0);
        check({tag, "_ld_x"}, ld_x, 0);
        check({tag, "_ld_y"}, ld_y, 0);
        check({tag, "_ld_style"}, ld_man_style, 0);
        check({tag, "_x"}, x_out, 25);
        check({tag, "_y"}, y_out, 28);
        check({tag, "_style"}, man_style, 1);
    endtask

    task automatic bring_up(input string tag);
        reset = 1'b0;
        tick();
        tick();
        check({tag, "_floors_rise"}, drawing_floors, 1);
        for (int i = 0; i < 10; i++) begin
            check({tag, "_floors_hold"}, drawing_floors, 1);
            check({tag, "_floors_plot"}, plot, 1);
            check({tag, "_floors_ld"}, ld_x, 0);
            drive_ignored_keys();
            tick();
        end
        jump_key = 1'b0;
        crouch_key = 1'b0;
        draw_floors_finish = 1'b1;
        tick();
        draw_floors_finish = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        bring_up("boot");

        for (int f = 0; f < FRAMES; f++) run_frame();

        // Reset asserted in the middle of a sprite draw.
        check_load();
        draw_man_finish = 1'b0;
        jump_key = 1'b0;
        crouch_key = 1'b0;
        tick();
        check("pre_reset_draw", draw_man, 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        bring_up("reboot");
        check_load();

        $display("info: lane wraps=%0d, edge holds=%0d", wraps, holds);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
